// File: rtl/keyed_burst_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keyed_ctrl_pkg
// Brief    : Shared flow-state encoding and mode constants for the
//            keyed burst controller.
// Revision : 1.0
// ============================================================================
package keyed_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ACC  = 3'd1,
        ST_RD_LOAD = 3'd2,
        ST_RD_TX   = 3'd3,
        ST_WR      = 3'd4,
        ST_TX_LOAD = 3'd5,
        ST_TX_WAIT = 3'd6
    } flow_state_t;

    localparam logic MODE_MEM = 1'b1;
    localparam logic MODE_TX  = 1'b0;

    localparam int FAIL_CNT_W = 4;

    // States in which the Tx-done watchdog runs.
    function automatic logic is_tx_state(input flow_state_t s);
        return (s == ST_RD_TX) || (s == ST_TX_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keyed_burst_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : keyed_burst_controller_if
// Brief    : Command / memory / Tx signal bundle of the keyed burst
//            controller. Direction names are from the controller's view.
// Revision : 1.0
// ============================================================================
interface keyed_burst_controller_if #(
    parameter int BURST_W = 3
);
    logic               i_input_key;
    logic               i_valid_cmd;
    logic               i_exit_cmd;
    logic               i_rw;
    logic [BURST_W-1:0] i_burst_len;
    logic               i_tx_done;
    logic               o_active;
    logic               o_mode;
    logic               o_locked;
    logic               o_access_mem;
    logic               o_rw_mem;
    logic               o_parallel_load;
    logic               o_tx_data;
    logic               o_busy;
    logic [BURST_W-1:0] o_word_idx;
    logic               o_timeout_err;

    modport master (
        output i_input_key, i_valid_cmd, i_exit_cmd, i_rw, i_burst_len, i_tx_done,
        input  o_active, o_mode, o_locked, o_access_mem, o_rw_mem,
               o_parallel_load, o_tx_data, o_busy, o_word_idx, o_timeout_err
    );

    modport slave (
        input  i_input_key, i_valid_cmd, i_exit_cmd, i_rw, i_burst_len, i_tx_done,
        output o_active, o_mode, o_locked, o_access_mem, o_rw_mem,
               o_parallel_load, o_tx_data, o_busy, o_word_idx, o_timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/keyed_burst_controller_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : key_decoder
// Brief    : Serial key shifter/comparator with bad-key lockout; drives the
//            session ACTIVE/MODE flags.
// Revision : 1.0
// ============================================================================
module key_decoder
    import keyed_ctrl_pkg::*;
#(
    parameter int                  KEY_LEN  = 4,
    parameter logic [KEY_LEN-1:0]  KEY_RW   = 4'b1011,
    parameter logic [KEY_LEN-1:0]  KEY_TX   = 4'b0110,
    parameter int                  MAX_FAIL = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_valid,
    input  wire logic i_key,
    input  wire logic i_exit,
    output logic      o_active,
    output logic      o_mode,
    output logic      o_locked
);

    localparam int                     C_CNT_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [C_CNT_W-1:0]     C_LAST_BIT = C_CNT_W'(KEY_LEN - 1);
    localparam logic [FAIL_CNT_W-1:0]  C_MAX_FAIL = FAIL_CNT_W'(MAX_FAIL);

    logic [KEY_LEN-1:0]    r_shift;
    logic [C_CNT_W-1:0]    r_bit_cnt;
    logic [FAIL_CNT_W-1:0] r_fail_cnt;
    logic                  r_active;
    logic                  r_mode;
    logic                  r_locked;

    logic                  w_strobe;
    logic                  w_last;
    logic [KEY_LEN-1:0]    w_word;
    logic [FAIL_CNT_W-1:0] w_fail_inc;

    // Key bits are only consumed while no session is open and not locked out,
    // so the strobe that completes a key can never double as a command.
    assign w_strobe   = i_valid & ~r_active & ~r_locked;
    assign w_last     = (r_bit_cnt == C_LAST_BIT);
    assign w_word     = KEY_LEN'({r_shift, i_key});
    assign w_fail_inc = r_fail_cnt + FAIL_CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_fail_cnt <= '0;
            r_active   <= 1'b0;
            r_mode     <= 1'b0;
            r_locked   <= 1'b0;
        end else if (i_exit && r_active) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_fail_cnt <= '0;
            r_active   <= 1'b0;
            r_mode     <= 1'b0;
        end else if (w_strobe) begin
            if (w_last) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                if (w_word == KEY_RW) begin
                    r_active   <= 1'b1;
                    r_mode     <= MODE_MEM;
                    r_fail_cnt <= '0;
                end else if (w_word == KEY_TX) begin
                    r_active   <= 1'b1;
                    r_mode     <= MODE_TX;
                    r_fail_cnt <= '0;
                end else begin
                    r_fail_cnt <= w_fail_inc;
                    if (w_fail_inc == C_MAX_FAIL) begin
                        r_locked <= 1'b1;
                    end
                end
            end else begin
                r_shift   <= w_word;
                r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
            end
        end
    end

    assign o_active = r_active;
    assign o_mode   = r_mode;
    assign o_locked = r_locked;

endmodule
`default_nettype wire

// File: rtl/keyed_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : keyed_burst_controller
// Brief    : Key-gated controller sequencing memory read/write and direct-Tx
//            bursts with a Tx-done watchdog.
// Revision : 1.0
// ============================================================================
module keyed_burst_controller
    import keyed_ctrl_pkg::*;
#(
    parameter int                  KEY_LEN     = 4,
    parameter logic [KEY_LEN-1:0]  KEY_RW      = 4'b1011,
    parameter logic [KEY_LEN-1:0]  KEY_TX      = 4'b0110,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  BURST_W     = 3,
    parameter int                  TIMEOUT_CYC = 1024,
    parameter int                  TMR_W       = 11
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    keyed_burst_controller_if.slave bus
);

    localparam bit               C_WD_EN    = (TIMEOUT_CYC != 0);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    flow_state_t        r_state;
    flow_state_t        w_next;
    logic [BURST_W-1:0] r_word_idx;
    logic [BURST_W-1:0] r_burst_len;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_timeout_err;

    logic w_active;
    logic w_mode;
    logic w_idle;
    logic w_cmd;
    logic w_exit;
    logic w_expire;
    logic w_abort;
    logic w_rd_start;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_exit     = bus.i_valid_cmd & w_active & w_idle & bus.i_exit_cmd;
    assign w_cmd      = bus.i_valid_cmd & w_active & w_idle & ~bus.i_exit_cmd;
    assign w_rd_start = w_cmd & (w_mode == MODE_MEM) & ~bus.i_rw;
    assign w_expire   = C_WD_EN && (r_tmr == C_TMR_LAST);

    key_decoder #(
        .KEY_LEN  (KEY_LEN),
        .KEY_RW   (KEY_RW),
        .KEY_TX   (KEY_TX),
        .MAX_FAIL (MAX_FAIL)
    ) u_key_decoder (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (bus.i_valid_cmd),
        .i_key    (bus.i_input_key),
        .i_exit   (w_exit),
        .o_active (w_active),
        .o_mode   (w_mode),
        .o_locked (bus.o_locked)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // TX_DONE takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd) begin
                    if (w_mode == MODE_MEM) begin
                        w_next = bus.i_rw ? ST_WR : ST_RD_ACC;
                    end else begin
                        w_next = ST_TX_LOAD;
                    end
                end
            end
            ST_RD_ACC:  w_next = ST_RD_LOAD;
            ST_RD_LOAD: w_next = ST_RD_TX;
            ST_RD_TX: begin
                if (bus.i_tx_done) begin
                    w_next = (r_word_idx == r_burst_len) ? ST_IDLE : ST_RD_ACC;
                end else if (w_expire) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end
            end
            ST_WR:      w_next = ST_IDLE;
            ST_TX_LOAD: w_next = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (bus.i_tx_done) begin
                    w_next = ST_IDLE;
                end else if (w_expire) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_access_mem    = 1'b0;
        bus.o_rw_mem        = 1'b0;
        bus.o_parallel_load = 1'b0;
        bus.o_tx_data       = 1'b0;
        bus.o_busy          = 1'b0;
        case (r_state)
            ST_RD_ACC: begin
                bus.o_access_mem = 1'b1;
                bus.o_busy       = 1'b1;
            end
            ST_RD_LOAD, ST_TX_LOAD: begin
                bus.o_parallel_load = 1'b1;
                bus.o_busy          = 1'b1;
            end
            ST_RD_TX, ST_TX_WAIT: begin
                bus.o_tx_data = 1'b1;
                bus.o_busy    = 1'b1;
            end
            ST_WR: begin
                bus.o_access_mem = 1'b1;
                bus.o_rw_mem     = 1'b1;
                bus.o_busy       = 1'b1;
            end
            default: ;
        endcase
    end

    // Burst offset, watchdog timer and abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_idx    <= '0;
            r_burst_len   <= '0;
            r_tmr         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_abort;
            if (w_rd_start) begin
                r_word_idx  <= '0;
                r_burst_len <= bus.i_burst_len;
            end else if ((r_state == ST_RD_TX) && bus.i_tx_done && (r_word_idx != r_burst_len)) begin
                r_word_idx <= r_word_idx + BURST_W'(1);
            end
            if (is_tx_state(w_next) && (w_next != r_state)) begin
                r_tmr <= '0;
            end else if (is_tx_state(r_state)) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end
        end
    end

    assign bus.o_active      = w_active;
    assign bus.o_mode        = w_mode;
    assign bus.o_word_idx    = r_word_idx;
    assign bus.o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_keyed_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyed_burst_controller
// Brief    : Scoreboard bench for keyed_burst_controller (TIMEOUT_CYC=16).
// Revision : 1.0
// ============================================================================
module tb_keyed_burst_controller;

    localparam int BURST_W = 3;

    logic clk;
    logic rst_n;

    keyed_burst_controller_if #(.BURST_W(BURST_W)) bus ();

    keyed_burst_controller #(
        .KEY_LEN     (4),
        .KEY_RW      (4'b1011),
        .KEY_TX      (4'b0110),
        .MAX_FAIL    (3),
        .BURST_W     (BURST_W),
        .TIMEOUT_CYC (16),
        .TMR_W       (11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 1 = read access, 2 = write access, 3 = watchdog abort
        int idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pl     = 0;
    int   m_kind;
    exp_t m_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int idx);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        sb_q.push_back(e);
    endtask

    task automatic send_key(input logic [3:0] k);
        for (int i = 3; i >= 0; i--) begin
            bus.i_input_key = k[i];
            bus.i_valid_cmd = 1'b1;
            tick();
            bus.i_valid_cmd = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic rw, input logic [BURST_W-1:0] len);
        bus.i_rw        = rw;
        bus.i_burst_len = len;
        bus.i_valid_cmd = 1'b1;
        tick();
        bus.i_valid_cmd = 1'b0;
    endtask

    task automatic send_exit();
        bus.i_exit_cmd  = 1'b1;
        bus.i_valid_cmd = 1'b1;
        tick();
        bus.i_valid_cmd = 1'b0;
        bus.i_exit_cmd  = 1'b0;
    endtask

    task automatic pulse_done();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic wait_tx();
        int n;
        n = 0;
        while (!bus.o_tx_data && n < 40) begin
            tick();
            n++;
        end
        if (!bus.o_tx_data) chk("tx_data_wait", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return {bus.o_active, bus.o_mode, bus.o_locked, bus.o_access_mem, bus.o_rw_mem,
                bus.o_parallel_load, bus.o_tx_data, bus.o_busy, bus.o_timeout_err,
                bus.o_word_idx};
    endfunction

    // Scoreboard consumer: every access strobe and abort pulse must match.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_parallel_load) n_pl++;
            if (bus.o_access_mem || bus.o_timeout_err) begin
                m_kind = bus.o_timeout_err ? 3 : (bus.o_rw_mem ? 2 : 1);
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", m_kind, 0);
                end else begin
                    m_e = sb_q.pop_front();
                    chk("sb_kind", m_kind, m_e.kind);
                    if (m_e.kind == 1) chk("sb_idx", 32'(bus.o_word_idx), m_e.idx);
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.i_input_key = 1'b0;
        bus.i_valid_cmd = 1'b0;
        bus.i_exit_cmd  = 1'b0;
        bus.i_rw        = 1'b0;
        bus.i_burst_len = '0;
        bus.i_tx_done   = 1'b0;
        repeat (3) tick();
        chk("reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two bad keys, then a match clears the fail count.
        send_key(4'b0000);
        send_key(4'b0000);
        chk("two_bad_unlocked", bus.o_locked, 1'b0);
        send_key(4'b1011);
        chk("rw_key_active", bus.o_active, 1'b1);
        chk("rw_key_mode", bus.o_mode, 1'b1);

        // Single write.
        push(2, 0);
        send_cmd(1'b1, 3'd0);
        chk("wr_strobe", {bus.o_access_mem, bus.o_rw_mem, bus.o_busy}, 3'b111);
        tick();
        chk("wr_done", {bus.o_access_mem, bus.o_busy}, 2'b00);

        // Three-word read burst, with a command dropped while busy.
        n_pl = 0;
        push(1, 0);
        push(1, 1);
        push(1, 2);
        send_cmd(1'b0, 3'd2);
        chk("rd_first_acc", bus.o_access_mem, 1'b1);
        for (int w = 0; w < 3; w++) begin
            wait_tx();
            if (w == 0) begin
                send_cmd(1'b1, 3'd5);
                repeat (3) tick();
            end else begin
                repeat (4) tick();
            end
            pulse_done();
        end
        chk("rd_idle", bus.o_busy, 1'b0);
        chk("rd_idx_hold", 32'(bus.o_word_idx), 32'd2);
        chk("rd_pl_count", n_pl, 3);

        // Exit, then a Tx key.
        send_exit();
        chk("exit_flags", {bus.o_active, bus.o_mode}, 2'b00);
        send_key(4'b0110);
        chk("tx_key", {bus.o_active, bus.o_mode}, 2'b10);

        send_cmd(1'b0, 3'd0);
        chk("tx_load", {bus.o_parallel_load, bus.o_busy}, 2'b11);
        tick();
        chk("tx_wait", bus.o_tx_data, 1'b1);
        repeat (2) tick();
        pulse_done();
        chk("tx_done_idle", {bus.o_busy, bus.o_timeout_err}, 2'b00);

        // Watchdog expiry after 16 Tx cycles.
        push(3, 0);
        send_cmd(1'b0, 3'd0);
        tick();
        repeat (15) tick();
        chk("wd_still_tx", bus.o_tx_data, 1'b1);
        tick();
        chk("wd_abort", {bus.o_busy, bus.o_timeout_err}, 2'b01);
        tick();
        chk("wd_pulse_end", bus.o_timeout_err, 1'b0);

        // TX_DONE on the expiry cycle wins.
        send_cmd(1'b0, 3'd0);
        tick();
        repeat (15) tick();
        pulse_done();
        chk("wd_tie_idle", {bus.o_busy, bus.o_timeout_err}, 2'b00);
        tick();
        chk("wd_tie_noerr", bus.o_timeout_err, 1'b0);

        // Lockout.
        send_exit();
        send_key(4'b0000);
        send_key(4'b0000);
        chk("lock_not_yet", bus.o_locked, 1'b0);
        send_key(4'b0000);
        chk("locked", bus.o_locked, 1'b1);
        send_key(4'b1011);
        chk("locked_inactive", bus.o_active, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("lock_reset", bus.o_locked, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Async reset in the middle of a burst.
        send_key(4'b1011);
        chk("rekey_active", bus.o_active, 1'b1);
        push(1, 0);
        push(1, 1);
        send_cmd(1'b0, 3'd3);
        wait_tx();
        repeat (2) tick();
        pulse_done();
        wait_tx();
        chk("mid_idx", 32'(bus.o_word_idx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keyed_burst_controller.md
Name: keyed_burst_controller

Overview:
Parametrised successor to the key-gated memory/serial-Tx controller.
- Decodes a serial INPUT_KEY sequence of configurable length into ACTIVE/MODE.
- Enforces a lockout after repeated bad keys.
- Sequences memory reads, writes and direct-Tx transfers as multi-word bursts, with a Tx-done watchdog.
- Sits between the command front-end and the memory / parallel-load shift-register / UART Tx path.

Parameters:
KEY_LEN, 4, number of key bits per key attempt
KEY_RW, 4'b1011, KEY_LEN-bit code that activates memory mode (MODE=1)
KEY_TX, 4'b0110, KEY_LEN-bit code that activates direct-Tx mode (MODE=0)
MAX_FAIL, 3, consecutive bad keys before lockout (1..15)
BURST_W, 3, width of BURST_LEN/WORD_IDX; max burst = 2**BURST_W words
TIMEOUT_CYC, 1024, cycles waiting for TX_DONE before abort; 0 disables
TMR_W, 11, timer width; must hold TIMEOUT_CYC

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  async active-low reset
INPUT_KEY  in  1  key bit, sampled with VALID_CMD
VALID_CMD  in  1  one-cycle strobe: key bit or command
EXIT_CMD  in  1  qualifies VALID_CMD as deactivate request
RW  in  1  0=read, 1=write (memory mode)
BURST_LEN  in  BURST_W  words-1 for read burst, sampled at command accept
TX_DONE  in  1  Tx finished current word
ACTIVE  out  1  key accepted, session open
MODE  out  1  1=memory mode, 0=direct-Tx mode
LOCKED  out  1  lockout after MAX_FAIL bad keys
ACCESS_MEM  out  1  memory access strobe
RW_MEM  out  1  memory write enable (valid with ACCESS_MEM)
PARALLEL_LOAD  out  1  load Tx shift register
TX_DATA  out  1  start/hold Tx
BUSY  out  1  flow in progress; commands ignored
WORD_IDX  out  BURST_W  current burst word offset (memory address offset)
TIMEOUT_ERR  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (RESET_N=0, async): all outputs 0.
  - Key shift register, bit count and fail count cleared.
  - Flow state = IDLE.
  - LOCKED is cleared only by reset.
- Key decode (ACTIVE=0, LOCKED=0):
  - Each VALID_CMD shifts INPUT_KEY in, LSB side, first bit ends as MSB.
  - On the KEY_LEN-th bit, the full word is compared.
    - Match KEY_RW: ACTIVE=1, MODE=1 next edge.
    - Match KEY_TX: ACTIVE=1, MODE=0 next edge.
    - If KEY_RW==KEY_TX, RW wins.
    - Match clears fail count.
    - Mismatch: fail count +1; at MAX_FAIL, LOCKED=1 next edge.
  - Bit count resets after every compare.
  - EXIT_CMD, RW and BURST_LEN are ignored while inactive.
  - The completing key strobe is never treated as a command.
- LOCKED=1: all VALID_CMD ignored; ACTIVE stays 0.
- Session (ACTIVE=1):
  - VALID_CMD & EXIT_CMD in IDLE: ACTIVE=0 and MODE=0 next edge; key logic restarts clean.
  - VALID_CMD with EXIT_CMD=0 in IDLE is a command.
  - Any VALID_CMD while BUSY is dropped; it is not queued.
- Flow FSM: Moore outputs decoded from the state register. Outputs not listed are 0.
  - IDLE (all 0):
    - Command with MODE=1, RW=0 -> RD_ACC; latch BURST_LEN; WORD_IDX=0.
    - Command with MODE=1, RW=1 -> WR.
    - Command with MODE=0 -> TX_LOAD.
  - RD_ACC: ACCESS_MEM=1, BUSY=1 -> RD_LOAD.
  - RD_LOAD: PARALLEL_LOAD=1, BUSY=1 -> RD_TX.
  - RD_TX: TX_DATA=1, BUSY=1.
    - Holds until TX_DONE sampled 1.
    - If WORD_IDX==latched length -> IDLE; else WORD_IDX+1 -> RD_ACC.
  - WR: ACCESS_MEM=1, RW_MEM=1, BUSY=1, exactly one cycle -> IDLE.
  - TX_LOAD: PARALLEL_LOAD=1, BUSY=1 -> TX_WAIT.
  - TX_WAIT: TX_DATA=1, BUSY=1 until TX_DONE -> IDLE.
- Latency and WORD_IDX:
  - First ACCESS_MEM is 1 cycle after the accepted command.
  - Each read word costs 3 + Tx cycles.
  - WORD_IDX holds its value after a burst until the next read command.
- Watchdog:
  - Timer clears on entry to RD_TX/TX_WAIT and counts each cycle there.
  - On reaching TIMEOUT_CYC without TX_DONE: -> IDLE, TIMEOUT_ERR=1 for one cycle, remaining burst abandoned.
  - TX_DONE in the same cycle as expiry: TX_DONE wins, no error.
  - TIMEOUT_CYC=0 disables the watchdog.
- TX_DONE outside RD_TX/TX_WAIT is ignored.
- Illegal state encodings -> IDLE.

Decomposition:
- Package keyed_ctrl_pkg:
  - flow state typedef (IDLE, RD_ACC, RD_LOAD, RD_TX, WR, TX_LOAD, TX_WAIT);
  - mode constants MODE_MEM=1, MODE_TX=0.
- Sub-module key_decoder:
  - owns the shift register, bit count, fail count and LOCKED;
  - drives ACTIVE/MODE;
  - takes an exit pulse from the parent.
- Flow FSM, burst counter and watchdog stay in the top module.

Test Plan:
- Key 1,0,1,1 with VALID_CMD -> ACTIVE=1, MODE=1 one cycle after the 4th strobe; then RW=1 command -> ACCESS_MEM=RW_MEM=BUSY=1 for exactly 1 cycle.
- MODE=1, RW=0, BURST_LEN=2, TX_DONE 5 cycles after each TX_DATA rise -> 3 ACCESS_MEM/PARALLEL_LOAD/TX_DATA triples with WORD_IDX 0,1,2, then IDLE, BUSY=0.
- Key 0,1,1,0 -> MODE=0; command -> PARALLEL_LOAD 1 cycle, TX_DATA until TX_DONE; TX_DONE withheld with TIMEOUT_CYC=16 -> TIMEOUT_ERR pulse, BUSY=0 at cycle 16.
- Three wrong keys (0000) -> LOCKED=1; a following correct key leaves ACTIVE=0; RESET_N low -> LOCKED=0.
- VALID_CMD during BUSY is ignored with no extra access; VALID_CMD with EXIT_CMD=1 in IDLE -> ACTIVE=0, MODE=0; a new key is then accepted.
- RESET_N asserted mid-RD_TX -> all outputs 0 immediately (async), WORD_IDX=0; TX_DONE and expiry in the same cycle -> no TIMEOUT_ERR.
